ps2_num_entry: RTL

Parametrised PS/2 keyboard front end for the calculator datapath. Receives and validates PS/2 frames, decodes make/break/extended codes, and accumulates up to DIGITS decimal keys as BCD. Enter converts the BCD to binary and delivers the result through a valid/ready handshake into one of NUM_SLOTS rotating operand slots. Operator keys are reported on a separate pulse interface.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_frame_rx.sv | 111 +++++++++++
 rtl/ps2_num_entry.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared scan codes, operator encoding and receiver state type for the PS/2 number entry block.
package ps2_pkg;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ADD_KP = 8'h79;
    localparam logic [7:0] SC_ADD    = 8'h15;
    localparam logic [7:0] SC_SUB_KP = 8'h7B;
    localparam logic [7:0] SC_SUB    = 8'h1D;
    localparam logic [7:0] SC_MUL_KP = 8'h7C;
    localparam logic [7:0] SC_MUL    = 8'h22;
    localparam logic [7:0] SC_DIV    = 8'h4A;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpMul = 4'd2,
        OpDiv = 4'd3
    } op_code_e;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        CHECK
    } rx_state_e;

    // Returns {is_digit, value} for the keypad digit scan codes.
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        case (code)
            8'h70:   digit_of = 5'h10;
            8'h69:   digit_of = 5'h11;
            8'h72:   digit_of = 5'h12;
            8'h7A:   digit_of = 5'h13;
            8'h6B:   digit_of = 5'h14;
            8'h73:   digit_of = 5'h15;
            8'h74:   digit_of = 5'h16;
            8'h6C:   digit_of = 5'h17;
            8'h75:   digit_of = 5'h18;
            8'h7D:   digit_of = 5'h19;
            default: digit_of = 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchroniser, start/data/parity/stop capture and partial-frame
// timeout. Emits one code_valid cycle per good frame and an err_parity pulse per bad one.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       err_parity
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    rx_state_e   state_q, state_d;
    logic [2:0]  clk_sync_q, clk_sync_d;  // [0],[1] synchroniser, [2] previous sample
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]  code_q, code_d;
    logic        code_valid_q, code_valid_d;
    logic        err_q, err_d;
    logic        fall;
    logic        data;

    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign data = dat_sync_q[1];

    always_comb begin
        clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d   = {dat_sync_q[0], ps2_data};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        if (fall) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
        case (state_q)
            IDLE: begin
                if (fall && !data) begin
                    state_d   = RX;
                    bit_cnt_d = '0;
                end
            end
            RX: begin
                if (fall) begin
                    shift_d = {data, shift_q[9:1]};
                    if (bit_cnt_q == 4'd9) begin
                        state_d = CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = IDLE;
                // Data plus parity must hold an odd number of ones, stop bit high.
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    code_valid_d = 1'b1;
                    code_d       = shift_q[7:0];
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_sync_q   <= 3'b111;
            dat_sync_q   <= 2'b11;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign err_parity = err_q;

endmodule

// File: rtl/ps2_num_entry.sv
// PS/2 keypad number entry: BCD digit accumulation, BCD-to-binary on Enter, round-robin operand
// slots with valid/ready output and operator pulses. Backspace key enabled by PS2_BACKSPACE_EN.
module ps2_num_entry
    import ps2_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned NUM_SLOTS   = 3,
    parameter int unsigned VAL_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 50000,
    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_value,
    output logic [SW-1:0]    out_slot,
    output logic             op_valid,
    output logic [3:0]       op_code,
    output logic [3:0]       digit_cnt,
    output logic             err_parity,
    output logic             overrun
);

    localparam int unsigned BW = 4 * DIGITS;

    logic [7:0] rx_code;
    logic       rx_valid;
    logic [4:0] dig;

    logic             brk_q, brk_d, ext_q, ext_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic             conv_q, conv_d;
    logic [3:0]       conv_idx_q, conv_idx_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [VAL_W-1:0] out_value_q, out_value_d;
    logic [SW-1:0]    out_slot_q, out_slot_d;
    logic             op_valid_q, op_valid_d;
    op_code_e         op_code_q, op_code_d;
    logic             overrun_q, overrun_d;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (rx_code),
        .code_valid(rx_valid),
        .err_parity(err_parity)
    );

    assign dig = digit_of(rx_code);

    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        conv_d      = conv_q;
        conv_idx_d  = conv_idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_slot_d  = out_slot_q;
        op_valid_d  = 1'b0;
        op_code_d   = op_code_q;
        overrun_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            slot_d = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
        end

        if (conv_q) begin
            // Most significant digit sits at nibble cnt-1; walk down to nibble 0.
            acc_d = acc_q * VAL_W'(10) + VAL_W'(4'(bcd_q >> {conv_idx_q, 2'b00}));
            if (conv_idx_q == 4'd0) begin
                conv_d      = 1'b0;
                out_valid_d = 1'b1;
                out_value_d = acc_d;
                out_slot_d  = slot_q;
                bcd_d       = '0;
                cnt_d       = '0;
            end else begin
                conv_idx_d = conv_idx_q - 4'd1;
            end
        end else if (rx_valid) begin
            if (rx_code == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_code == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!brk_q) begin
                    case (rx_code)
                        SC_ENTER: begin
                            if (cnt_q != 4'd0) begin
                                if (out_valid_q) begin
                                    overrun_d = 1'b1;
                                end else begin
                                    conv_d     = 1'b1;
                                    conv_idx_d = cnt_q - 4'd1;
                                    acc_d      = '0;
                                end
                            end
                        end
                        SC_ADD_KP, SC_ADD: begin
                            op_valid_d = 1'b1;
                            op_code_d  = OpAdd;
                        end
                        SC_SUB_KP, SC_SUB: begin
                            op_valid_d = 1'b1;
                            op_code_d  = OpSub;
                        end
                        SC_MUL_KP, SC_MUL: begin
                            op_valid_d = 1'b1;
                            op_code_d  = OpMul;
                        end
                        SC_DIV: begin
                            if (ext_q) begin
                                op_valid_d = 1'b1;
                                op_code_d  = OpDiv;
                            end
                        end
`ifdef PS2_BACKSPACE_EN
                        SC_BKSP: begin
                            if (cnt_q != 4'd0) begin
                                bcd_d = bcd_q >> 4;
                                cnt_d = cnt_q - 4'd1;
                            end
                        end
`endif
                        default: begin
                            if (dig[4] && cnt_q != 4'(DIGITS)) begin
                                bcd_d = (bcd_q << 4) | BW'(dig[3:0]);
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    endcase
                end
            end
        end

        // A pending operand survives clear; only the entry state and pointer are flushed.
        if (clear) begin
            bcd_d  = '0;
            cnt_d  = '0;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
            slot_d = '0;
            conv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            conv_q      <= 1'b0;
            conv_idx_q  <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_slot_q  <= '0;
            op_valid_q  <= 1'b0;
            op_code_q   <= OpAdd;
            overrun_q   <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            conv_q      <= conv_d;
            conv_idx_q  <= conv_idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_slot_q  <= out_slot_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_slot  = out_slot_q;
    assign op_valid  = op_valid_q;
    assign op_code   = op_code_q;
    assign digit_cnt = cnt_q;
    assign overrun   = overrun_q;

endmodule
